// File: rtl/m6502_irq_ctrl.sv
// m6502_irq_ctrl: multi-source interrupt front end for the 6502 core.
// Synchronises N_SRC raw requests, latches edge events or follows levels per source, masks
// them, picks the lowest-index active source and drives the core's irq_n. During the core's
// vector pull (ack = vpa) it presents a per-source vector address VEC_BASE + 2*id.
//
// Ports:
//   clk        system clock, rising edge
//   res_n      asynchronous active-low reset
//   irq_src    raw asynchronous requests, active high
//   edge_mode  per source: 1 = rising-edge latched, 0 = level
//   mask_wr    load mask from mask_di this cycle
//   mask_di    new mask value (1 = enabled)
//   ack        core vector-pull strobe
//   irq_n      registered interrupt request to the core, active low
//   vec_valid  vec_addr / vec_id valid for the current vector pull
//   vec_addr   vector address of the acknowledged source
//   vec_id     index of the acknowledged source
//   pending    raw pending register, before the mask
//   mask       current enable mask
module m6502_irq_ctrl #(
  parameter int unsigned N_SRC       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [15:0] VEC_BASE    = 16'hFFD0,
  parameter logic [N_SRC-1:0] MASK_RST = '1,
  localparam int unsigned ID_W       = $clog2(N_SRC)
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic [N_SRC-1:0] irq_src,
  input  logic [N_SRC-1:0] edge_mode,
  input  logic             mask_wr,
  input  logic [N_SRC-1:0] mask_di,
  input  logic             ack,
  output logic             irq_n,
  output logic             vec_valid,
  output logic [15:0]      vec_addr,
  output logic [ID_W-1:0]  vec_id,
  output logic [N_SRC-1:0] pending,
  output logic [N_SRC-1:0] mask
);

  typedef enum logic [1:0] {StIdle, StReq, StVec, StGap} state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0][N_SRC-1:0] sync_q;
  logic [N_SRC-1:0] s_d_q;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [N_SRC-1:0] mask_q;
  logic             ack_q;
  logic             irq_n_q, irq_n_d;
  logic             vec_valid_q, vec_valid_d;
  logic [15:0]      vec_addr_q, vec_addr_d;
  logic [ID_W-1:0]  vec_id_q, vec_id_d;

  logic [N_SRC-1:0] s;
  logic [N_SRC-1:0] s_nxt;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] act;
  logic             act_any;
  logic [ID_W-1:0]  winner;
  logic [N_SRC-1:0] clr;
  logic             ack_rise;

  // Input synchroniser plus one extra flop for rising-edge detection.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      sync_q <= '0;
      s_d_q  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], irq_src};
      s_d_q  <= s;
    end
  end

  assign s     = sync_q[SYNC_STAGES-1];
  // Value s takes after this edge; loading it makes level pending bits identical to s.
  assign s_nxt = sync_q[SYNC_STAGES-2];
  assign rise  = s & ~s_d_q;

  assign act      = pending_q & mask_q;
  assign act_any  = |act;
  assign ack_rise = ack & ~ack_q;

  // Lowest set index wins; scan downwards so the last assignment is the lowest.
  always_comb begin
    winner = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (act[i]) begin
        winner = ID_W'(i);
      end
    end
  end

  // Edge bits: set wins over a same-cycle clear. Level bits just follow the synchronised pin.
  assign pending_d = (edge_mode & ((pending_q & ~clr) | rise)) | (~edge_mode & s_nxt);

  always_comb begin
    state_d     = state_q;
    irq_n_d     = 1'b1;
    vec_valid_d = vec_valid_q;
    vec_addr_d  = vec_addr_q;
    vec_id_d    = vec_id_q;
    clr         = '0;
    case (state_q)
      StIdle: begin
        // Acks here are NMI/reset pulls and are ignored.
        vec_valid_d = 1'b0;
        if (act_any) begin
          state_d = StReq;
        end
      end
      StReq: begin
        vec_valid_d = 1'b0;
        if (!act_any) begin
          state_d = StIdle;
        end else if (ack_rise) begin
          state_d     = StVec;
          vec_valid_d = 1'b1;
          vec_id_d    = winner;
          vec_addr_d  = VEC_BASE + (16'(winner) << 1);
          clr         = edge_mode & (N_SRC'(1) << winner);
        end else begin
          irq_n_d = 1'b0;
        end
      end
      StVec: begin
        // Hold the vector across both byte fetches.
        if (!ack) begin
          vec_valid_d = 1'b0;
          state_d     = StGap;
        end
      end
      StGap: begin
        vec_valid_d = 1'b0;
        state_d     = StIdle;
      end
      default: begin
        vec_valid_d = 1'b0;
        state_d     = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q     <= StIdle;
      pending_q   <= '0;
      mask_q      <= MASK_RST;
      ack_q       <= 1'b0;
      irq_n_q     <= 1'b1;
      vec_valid_q <= 1'b0;
      vec_addr_q  <= VEC_BASE;
      vec_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      ack_q       <= ack;
      irq_n_q     <= irq_n_d;
      vec_valid_q <= vec_valid_d;
      vec_addr_q  <= vec_addr_d;
      vec_id_q    <= vec_id_d;
      if (mask_wr) begin
        mask_q <= mask_di;
      end
    end
  end

  assign irq_n     = irq_n_q;
  assign vec_valid = vec_valid_q;
  assign vec_addr  = vec_addr_q;
  assign vec_id    = vec_id_q;
  assign pending   = pending_q;
  assign mask      = mask_q;

endmodule

// File: tb/tb_m6502_irq_ctrl.sv
// Self-checking bench for m6502_irq_ctrl: directed vector table, hand-written corner
// sequences and a randomised run against a transaction-level reference model.
module tb_m6502_irq_ctrl;

  localparam int unsigned N = 8;
  localparam int unsigned S = 2;
  localparam logic [15:0] BASE = 16'hFFD0;

  logic        clk;
  logic        res_n;
  logic [7:0]  irq_src;
  logic [7:0]  edge_mode;
  logic        mask_wr;
  logic [7:0]  mask_di;
  logic        ack;
  logic        irq_n;
  logic        vec_valid;
  logic [15:0] vec_addr;
  logic [2:0]  vec_id;
  logic [7:0]  pending;
  logic [7:0]  mask;

  int checks = 0;
  int errors = 0;

  m6502_irq_ctrl #(
    .N_SRC      (N),
    .SYNC_STAGES(S),
    .VEC_BASE   (BASE),
    .MASK_RST   (8'hFF)
  ) dut (
    .clk      (clk),
    .res_n    (res_n),
    .irq_src  (irq_src),
    .edge_mode(edge_mode),
    .mask_wr  (mask_wr),
    .mask_di  (mask_di),
    .ack      (ack),
    .irq_n    (irq_n),
    .vec_valid(vec_valid),
    .vec_addr (vec_addr),
    .vec_id   (vec_id),
    .pending  (pending),
    .mask     (mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_src(input int idx);
    irq_src[idx] = 1'b1;
    tick();
    irq_src[idx] = 1'b0;
  endtask

  task automatic wait_irq(input logic val, input int bound, input string name);
    int k = 0;
    while (irq_n !== val && k < bound) begin
      tick();
      k++;
    end
    chk(name, 64'(irq_n), 64'(val));
  endtask

  // ---------------- reference model ----------------
  typedef enum int {Quiet, Asserting, Pulling, Cooling} phase_e;
  phase_e      m_phase;
  logic [7:0]  m_hist [S+2];  // m_hist[0] = pin value at the latest edge
  logic [7:0]  m_pend, m_mask;
  logic        m_ack_prev, m_irq_n, m_vv;
  logic [15:0] m_addr;
  logic [2:0]  m_id;

  task automatic model_reset();
    m_phase = Quiet;
    for (int i = 0; i < S + 2; i++) m_hist[i] = '0;
    m_pend = '0; m_mask = 8'hFF; m_ack_prev = 1'b0;
    m_irq_n = 1'b1; m_vv = 1'b0; m_addr = BASE; m_id = '0;
  endtask

  // One rising edge: inputs are the values sampled at that edge.
  task automatic model_step(input logic [7:0] src, input logic [7:0] em, input logic mwr,
                            input logic [7:0] mdi, input logic a);
    logic [7:0] act, clr, rise, lvl;
    int win;
    act = m_pend & m_mask;
    win = -1;
    for (int i = 0; i < N; i++) if (act[i] && win < 0) win = i;
    clr = '0;
    case (m_phase)
      Quiet: begin
        m_irq_n = 1'b1;
        if (act != 0) m_phase = Asserting;
      end
      Asserting: begin
        if (act == 0) begin
          m_irq_n = 1'b1; m_phase = Quiet;
        end else if (a && !m_ack_prev) begin
          m_id = 3'(win); m_addr = BASE + 16'(2 * win);
          if (em[win]) clr[win] = 1'b1;
          m_vv = 1'b1; m_irq_n = 1'b1; m_phase = Pulling;
        end else begin
          m_irq_n = 1'b0;
        end
      end
      Pulling: if (!a) begin
        m_vv = 1'b0; m_phase = Cooling;
      end
      default: m_phase = Quiet;
    endcase
    for (int i = S + 1; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = src;
    rise = m_hist[S] & ~m_hist[S+1];  // pin edge seen S+1 edges ago
    lvl  = m_hist[S-1];               // synchronised pin after this edge
    for (int i = 0; i < N; i++)
      m_pend[i] = em[i] ? ((m_pend[i] & ~clr[i]) | rise[i]) : lvl[i];
    if (mwr) m_mask = mdi;
    m_ack_prev = a;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0]  src;
    logic        ack;
    logic        irq_n;
    logic        vv;
    logic [15:0] addr;
    logic [2:0]  id;
    logic [7:0]  pend;
  } vec_t;

  vec_t tbl [10];

  initial begin
    int ack_len;
    tbl[0] = '{8'h08, 1'b0, 1'b1, 1'b0, 16'hFFD0, 3'd0, 8'h00};
    tbl[1] = '{8'h00, 1'b0, 1'b1, 1'b0, 16'hFFD0, 3'd0, 8'h00};
    tbl[2] = '{8'h00, 1'b0, 1'b1, 1'b0, 16'hFFD0, 3'd0, 8'h08};
    tbl[3] = '{8'h00, 1'b0, 1'b1, 1'b0, 16'hFFD0, 3'd0, 8'h08};
    tbl[4] = '{8'h00, 1'b0, 1'b0, 1'b0, 16'hFFD0, 3'd0, 8'h08};
    tbl[5] = '{8'h00, 1'b1, 1'b1, 1'b1, 16'hFFD6, 3'd3, 8'h00};
    tbl[6] = '{8'h00, 1'b1, 1'b1, 1'b1, 16'hFFD6, 3'd3, 8'h00};
    tbl[7] = '{8'h00, 1'b0, 1'b1, 1'b0, 16'hFFD6, 3'd3, 8'h00};
    tbl[8] = '{8'h00, 1'b0, 1'b1, 1'b0, 16'hFFD6, 3'd3, 8'h00};
    tbl[9] = '{8'h00, 1'b0, 1'b1, 1'b0, 16'hFFD6, 3'd3, 8'h00};

    // 1: reset with all requests high
    res_n = 1'b0; irq_src = 8'hFF; edge_mode = 8'h00;
    mask_wr = 1'b0; mask_di = 8'h00; ack = 1'b0;
    repeat (3) tick();
    chk("rst irq_n", 64'(irq_n), 64'd1);
    chk("rst vec_valid", 64'(vec_valid), 64'd0);
    chk("rst pending", 64'(pending), 64'h00);
    chk("rst mask", 64'(mask), 64'hFF);
    chk("rst vec_addr", 64'(vec_addr), 64'hFFD0);
    chk("rst vec_id", 64'(vec_id), 64'd0);
    res_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("post-rst vec_valid %0d", i), 64'(vec_valid), 64'd0);
    end
    irq_src = 8'h00;
    repeat (8) tick();
    chk("quiet irq_n", 64'(irq_n), 64'd1);
    chk("quiet pending", 64'(pending), 64'h00);

    // 2: edge source 3, table-driven cycle by cycle
    edge_mode = 8'h08;
    for (int i = 0; i < 10; i++) begin
      irq_src = tbl[i].src;
      ack = tbl[i].ack;
      tick();
      chk($sformatf("t2 row%0d irq_n", i), 64'(irq_n), 64'(tbl[i].irq_n));
      chk($sformatf("t2 row%0d vec_valid", i), 64'(vec_valid), 64'(tbl[i].vv));
      chk($sformatf("t2 row%0d vec_addr", i), 64'(vec_addr), 64'(tbl[i].addr));
      chk($sformatf("t2 row%0d vec_id", i), 64'(vec_id), 64'(tbl[i].id));
      chk($sformatf("t2 row%0d pending", i), 64'(pending), 64'(tbl[i].pend));
    end

    // 3: level 5 + edge 2, priority then second pull
    edge_mode = 8'h04;
    irq_src = 8'h24;
    tick();
    irq_src = 8'h20;
    wait_irq(1'b0, 8, "t3 irq low 1");
    ack = 1'b1; tick();
    chk("t3 id1", 64'(vec_id), 64'd2);
    chk("t3 addr1", 64'(vec_addr), 64'hFFD4);
    chk("t3 pend1", 64'(pending), 64'h20);
    tick(); ack = 1'b0; tick();
    chk("t3 vv drop", 64'(vec_valid), 64'd0);
    wait_irq(1'b0, 6, "t3 irq low 2");
    ack = 1'b1; tick();
    chk("t3 id2", 64'(vec_id), 64'd5);
    chk("t3 addr2", 64'(vec_addr), 64'hFFDA);
    chk("t3 pend2", 64'(pending), 64'h20);
    ack = 1'b0; tick();
    irq_src = 8'h00;
    repeat (8) tick();
    chk("t3 pend cleared", 64'(pending), 64'h00);
    chk("t3 irq idle", 64'(irq_n), 64'd1);

    // 4: mask away a pending request while in REQ
    edge_mode = 8'h02;
    pulse_src(1);
    wait_irq(1'b0, 8, "t4 irq low");
    mask_wr = 1'b1; mask_di = 8'h00; tick();
    mask_wr = 1'b0;
    chk("t4 mask", 64'(mask), 64'h00);
    tick();
    chk("t4 irq released", 64'(irq_n), 64'd1);
    repeat (3) tick();
    chk("t4 irq stays", 64'(irq_n), 64'd1);
    chk("t4 pend kept", 64'(pending), 64'h02);
    mask_wr = 1'b1; mask_di = 8'hFF; tick();
    mask_wr = 1'b0;
    wait_irq(1'b0, 5, "t4 irq after unmask");
    ack = 1'b1; tick();
    chk("t4 id", 64'(vec_id), 64'd1);
    chk("t4 addr", 64'(vec_addr), 64'hFFD2);
    ack = 1'b0; repeat (3) tick();
    chk("t4 pend cleared", 64'(pending), 64'h00);

    // 5: ack while idle, then set/clear collision on src 0
    edge_mode = 8'h01;
    ack = 1'b1; tick(); tick();
    chk("t5 idle ack vv", 64'(vec_valid), 64'd0);
    chk("t5 idle ack pend", 64'(pending), 64'h00);
    chk("t5 idle ack irq", 64'(irq_n), 64'd1);
    ack = 1'b0; tick();
    pulse_src(0);
    wait_irq(1'b0, 8, "t5 irq low");
    irq_src[0] = 1'b1; tick();
    irq_src[0] = 1'b0; tick();
    ack = 1'b1; tick();
    chk("t5 vv", 64'(vec_valid), 64'd1);
    chk("t5 id", 64'(vec_id), 64'd0);
    chk("t5 set wins", 64'(pending), 64'h01);
    ack = 1'b0; tick();
    wait_irq(1'b0, 6, "t5 irq re-request");
    ack = 1'b1; tick(); ack = 1'b0; repeat (3) tick();
    chk("t5 pend cleared", 64'(pending), 64'h00);

    // 6: asynchronous reset during VEC
    edge_mode = 8'h10;
    mask_wr = 1'b1; mask_di = 8'hF0; tick(); mask_wr = 1'b0;
    pulse_src(4);
    wait_irq(1'b0, 8, "t6 irq low");
    ack = 1'b1; tick();
    chk("t6 in vec", 64'(vec_valid), 64'd1);
    #1 res_n = 1'b0;
    #1;
    chk("t6 async vv", 64'(vec_valid), 64'd0);
    chk("t6 async irq", 64'(irq_n), 64'd1);
    chk("t6 async mask", 64'(mask), 64'hFF);
    chk("t6 async addr", 64'(vec_addr), 64'hFFD0);
    ack = 1'b0;
    @(negedge clk) res_n = 1'b1;
    repeat (3) tick();
    chk("t6 idle irq", 64'(irq_n), 64'd1);
    chk("t6 idle vv", 64'(vec_valid), 64'd0);

    // Randomised run against the reference model
    @(negedge clk) res_n = 1'b0;
    irq_src = '0; ack = 1'b0; mask_wr = 1'b0; edge_mode = 8'($urandom);
    tick();
    model_reset();
    @(negedge clk) res_n = 1'b1;
    ack_len = 0;
    for (int c = 0; c < 4000; c++) begin
      if (c % 250 == 0) edge_mode = 8'($urandom);
      for (int b = 0; b < N; b++)
        if ($urandom_range(7) == 0) irq_src[b] = ~irq_src[b];
      mask_wr = ($urandom_range(15) == 0);
      mask_di = 8'($urandom) | 8'($urandom);
      if (ack_len > 0) begin
        ack = 1'b1; ack_len--;
      end else if ($urandom_range(5) == 0) begin
        ack = 1'b1; ack_len = int'($urandom_range(2));
      end else begin
        ack = 1'b0;
      end
      tick();
      model_step(irq_src, edge_mode, mask_wr, mask_di, ack);
      chk($sformatf("rand cyc%0d {irq_n,vv,addr,id,pend,mask}", c),
          64'({irq_n, vec_valid, vec_addr, vec_id, pending, mask}),
          64'({m_irq_n, m_vv, m_addr, m_id, m_pend, m_mask}));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
